iiitb_fifo_wr_arb: RTL and testbench
====================================

// Module: iiitb_fifo_wr_arb
// PURPOSE
//  Round-robin write-side arbiter sharing one iiitb_fifo write port among N_REQ producers.
//  - Grants one requester per cycle; a granted requester keeps ownership for a burst of up to MAX_BURST pushes.
//  - Throttles new bursts at a high watermark and never drives a push into a full FIFO.
//  - Sits directly in front of iiitb_fifo buf_in/wr_en; the read side is untouched.
// PARAMETERS
//  N_REQ      4  number of producers (>=2)
//  DATA_W     8  data width, equals FIFO buf_in width
//  BUF_WIDTH  3  FIFO depth = 2**BUF_WIDTH; fifo_counter is BUF_WIDTH+1 bits
//  MAX_BURST  4  max consecutive pushes per grant (>=1)
//  HIGH_WM    6  new burst starts only when fifo_counter < HIGH_WM (<= 2**BUF_WIDTH)
// PORTS
//  clk           in   1              single clock, all state updates on posedge
//  rst           in   1              synchronous, active-high reset
//  req           in   N_REQ          level request per producer
//  req_data      in   N_REQ*DATA_W   producer i data in bits [i*DATA_W +: DATA_W]
//  gnt           out  N_REQ          one-hot; data of gnt'd producer is pushed at this edge
//  fifo_wr_en    out  1              to FIFO wr_en
//  fifo_buf_in   out  DATA_W         to FIFO buf_in
//  fifo_buf_full in   1              from FIFO buf_full
//  fifo_counter  in   BUF_WIDTH+1    from FIFO fifo_counter
//  arb_busy      out  1              1 while in BURST
//  arb_owner     out  clog2(N_REQ)   current/last owner index
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset (rst) is synchronous, active-high.
//  - Registered state: st {IDLE,BURST}, owner, burst_cnt (counts to MAX_BURST), rr_ptr.
//  - gnt, fifo_wr_en and fifo_buf_in are combinational from the state plus the current inputs.
//    - Zero latency: push happens at the same edge gnt is high.
//    - fifo_wr_en = |gnt; fifo_buf_in = granted data, else 0.
//  - While rst=1: gnt=0 and fifo_wr_en=0 (forced). At the edge, st<=IDLE, owner<=0, burst_cnt<=0, rr_ptr<=0.
//  - IDLE: if |req & ~fifo_buf_full & fifo_counter<HIGH_WM:
//    - sel = first req set searching rr_ptr, rr_ptr+1, ... (mod N_REQ); gnt[sel]=1.
//    - owner<=sel, burst_cnt<=1.
//    - If MAX_BURST==1: rr_ptr<=sel+1 (mod N_REQ), stay IDLE; else st<=BURST.
//  - IDLE with the condition false: no grant, state held.
//  - BURST, req[owner]=1 and ~full: gnt[owner]=1, burst_cnt++.
//    - If burst_cnt+1==MAX_BURST: st<=IDLE, rr_ptr<=owner+1.
//    - HIGH_WM is not checked inside a burst.
//  - BURST, req[owner]=1 and full: stall; no grant, burst_cnt and state held.
//  - BURST, req[owner]=0: no grant; st<=IDLE, rr_ptr<=owner+1 (one dead cycle).
//  - Full with a simultaneous FIFO read: treated as full, no push.
//  - Producer rule: hold req_data stable while req=1 and not granted; may change or drop req the cycle after gnt.
//  - arb_busy=(st==BURST); arb_owner=owner. Both reset to 0.
// STRUCTURE
//  - Shared package iiitb_fifo_pkg:
//    - DATA_W, BUF_WIDTH defaults
//    - arbiter state encoding (IDLE=0, BURST=1)
//    - clog2 helper
//  - Sub-module iiitb_rr_pick: combinational rotating-priority picker (req, rr_ptr -> sel, valid).
//  - Top holds the FSM, counters and data mux.
// TESTING (defaults, FIFO initially empty)
//  1. req=0001, data0=0x0A, no pops -> gnt[0] for 8 consecutive cycles (burst of 4, then a new burst at counter 4<6), fifo_counter=8, then gnt=0.
//  2. req=1111, data 0x11/0x22/0x33/0x44, TB pops every cycle -> FIFO order 0x11 x4, 0x22 x4, 0x33 x4, 0x44 x4, 0x11...
//  3. Owner 2 in BURST after 2 pushes, FIFO full -> gnt=0 and arb_busy=1 until one pop; next cycle gnt[2], 2 more pushes, then IDLE.
//  4. Owner 1 drops req after 2 pushes, req[3] and req[0] set -> one cycle gnt=0, then gnt[3] (rr_ptr=2 search).
//  5. IDLE, fifo_counter=6, req=0010 -> no gnt; one pop (counter=5) -> gnt[1] that cycle.
//  6. rst=1 mid-burst (owner 3) -> gnt=0 that cycle, arb_busy=0, rr_ptr=0; after release with req=1010 -> gnt[1] first.

Source files
------------

// File: rtl/iiitb_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iiitb_fifo_pkg : shared defaults, arbiter state encoding, clog2 helper     |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
package iiitb_fifo_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int BUF_WIDTH_DEF = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Never returns less than 1 so single-entry selects still get a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iiitb_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iiitb_rr_pick : rotating-priority picker, first req at or after rr_ptr    |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module iiitb_rr_pick
  import iiitb_fifo_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [clog2(N_REQ)-1:0] rr_ptr,
  output logic [clog2(N_REQ)-1:0] sel,
  output logic                    valid
);

  localparam int PTR_W = clog2(N_REQ);
  localparam logic [PTR_W:0] N_EXT = (PTR_W + 1)'(N_REQ);

  // One extra bit so rr_ptr + offset never overflows before the wrap.
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (sum >= N_EXT) sum = sum - N_EXT;
      idx = sum[PTR_W-1:0];
      if (!valid && req[idx]) begin
        valid = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iiitb_fifo_wr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iiitb_fifo_wr_arb : round-robin burst arbiter for one FIFO write port     |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module iiitb_fifo_wr_arb
  import iiitb_fifo_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_WIDTH = BUF_WIDTH_DEF,
  parameter int MAX_BURST = 4,
  parameter int HIGH_WM   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_buf_in,
  input  logic                      fifo_buf_full,
  input  logic [BUF_WIDTH:0]        fifo_counter,
  output logic                      arb_busy,
  output logic [clog2(N_REQ)-1:0]   arb_owner
);

  localparam int PTR_W = clog2(N_REQ);
  localparam int CNT_W = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]   BURST_LAST = CNT_W'(MAX_BURST);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(N_REQ - 1);
  localparam logic [BUF_WIDTH:0] WM         = (BUF_WIDTH + 1)'(HIGH_WM);

  arb_state_t       st;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] rr_ptr;
  logic [CNT_W-1:0] burst_cnt;

  logic [PTR_W-1:0] sel;
  logic             pick_valid;
  logic             start_ok;
  logic             owner_req;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
    return (i == PTR_LAST) ? '0 : i + 1'b1;
  endfunction

  iiitb_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .sel    (sel),
    .valid  (pick_valid)
  );

  // The watermark only gates the start of a burst; an open burst may fill up to full.
  assign start_ok  = pick_valid && !fifo_buf_full && (fifo_counter < WM);
  assign owner_req = req[owner];
  assign cnt_inc   = burst_cnt + 1'b1;

  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (st == ARB_IDLE) begin
        if (start_ok) gnt[sel] = 1'b1;
      end else if (owner_req && !fifo_buf_full) begin
        gnt[owner] = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_buf_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) fifo_buf_in = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign fifo_wr_en = |gnt;
  assign arb_busy   = (st == ARB_BURST);
  assign arb_owner  = owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ARB_IDLE;
      owner     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      case (st)
        ARB_IDLE: begin
          if (start_ok) begin
            owner     <= sel;
            burst_cnt <= CNT_W'(1);
            if (MAX_BURST == 1) rr_ptr <= wrap_inc(sel);
            else                st     <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          // A dropped request ends the burst with one dead cycle.
          if (!owner_req) begin
            st     <= ARB_IDLE;
            rr_ptr <= wrap_inc(owner);
          end else if (!fifo_buf_full) begin
            burst_cnt <= cnt_inc;
            if (cnt_inc == BURST_LAST) begin
              st     <= ARB_IDLE;
              rr_ptr <= wrap_inc(owner);
            end
          end
        end
        default: st <= ARB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iiitb_fifo_wr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iiitb_fifo_wr_arb : directed bench with a behavioural FIFO model       |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module tb_iiitb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic        fifo_wr_en;
  logic [7:0]  fifo_buf_in;
  logic        fifo_buf_full;
  logic [3:0]  fifo_counter;
  logic        arb_busy;
  logic [1:0]  arb_owner;

  int checks = 0;
  int errors = 0;

  // FIFO model: depth 8, pops recorded in out_log
  logic [7:0] q[$];
  logic [7:0] out_log[$];
  int  cnt = 0;
  bit  pop = 1'b0;
  bit  flush = 1'b0;
  int  fill_to = -1;

  assign fifo_counter  = 4'(cnt);
  assign fifo_buf_full = (cnt >= 8);

  always #5 clk = ~clk;

  iiitb_fifo_wr_arb dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_buf_in   (fifo_buf_in),
    .fifo_buf_full (fifo_buf_full),
    .fifo_counter  (fifo_counter),
    .arb_busy      (arb_busy),
    .arb_owner     (arb_owner)
  );

  always @(posedge clk) begin
    bit was_full;
    if (flush) begin
      q.delete();
      out_log.delete();
    end else begin
      was_full = (q.size() >= 8);
      if (pop && q.size() > 0) out_log.push_back(q.pop_front());
      if (fifo_wr_en && !was_full) q.push_back(fifo_buf_in);
      if (fill_to >= 0) while (q.size() < fill_to) q.push_back(8'hEE);
    end
    cnt <= q.size();
  end

  task automatic apply_reset();
    rst = 1'b1; flush = 1'b1; req = '0; pop = 1'b0; fill_to = -1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; req = 4'hF; req_data = 32'h44332211;
    #1;
    checks++;
    if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: gnt=%b wr_en=%b, want 0000/0", gnt, fifo_wr_en);
    end
    @(negedge clk);
    checks++;
    if (arb_busy !== 1'b0 || arb_owner !== 2'd0) begin
      errors++; $display("FAIL reset_state: busy=%b owner=%0d, want 0/0", arb_busy, arb_owner);
    end
    rst = 1'b0; flush = 1'b0; req = '0;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    apply_reset();
    req_data = 32'h0000000A; req = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (gnt !== 4'b0001 || fifo_wr_en !== 1'b1 || fifo_buf_in !== 8'h0A) begin
        errors++; $display("FAIL single_burst[%0d]: gnt=%b wr=%b data=%h, want 0001/1/0a", k, gnt, fifo_wr_en, fifo_buf_in);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0 || fifo_buf_in !== 8'h00 || fifo_counter !== 4'd8) begin
      errors++; $display("FAIL single_full: gnt=%b wr=%b data=%h cnt=%0d, want 0000/0/00/8", gnt, fifo_wr_en, fifo_buf_in, fifo_counter);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    apply_reset();
    req_data = 32'h44332211; req = 4'hF; pop = 1'b1;
    for (int k = 0; k < 20; k++) begin
      exp_g = 4'b0001 << ((k / 4) % 4);
      #1;
      checks++;
      if (gnt !== exp_g) begin
        errors++; $display("FAIL rr_gnt[%0d]: gnt=%b, want %b", k, gnt, exp_g);
      end
      @(negedge clk);
    end
    req = '0;
    repeat (3) @(negedge clk);
    pop = 1'b0;
    checks++;
    if (out_log.size() < 20) begin
      errors++; $display("FAIL rr_count: popped=%0d, want >=20", out_log.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        exp_d = 8'h11 * 8'(((k / 4) % 4) + 1);
        checks++;
        if (out_log[k] !== exp_d) begin
          errors++; $display("FAIL rr_order[%0d]: data=%h, want %h", k, out_log[k], exp_d);
        end
      end
    end
  endtask

  // Leaves the DUT mid-burst with owner 3 and rr_ptr 2 for test_reset_mid_burst.
  task automatic test_drop_req();
    apply_reset();
    req_data = 32'h44332211; pop = 1'b1; req = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (gnt !== 4'b0010 || fifo_buf_in !== 8'h22) begin
        errors++; $display("FAIL drop_first[%0d]: gnt=%b data=%h, want 0010/22", k, gnt, fifo_buf_in);
      end
      @(negedge clk);
    end
    req = 4'b1001;
    #1;
    checks++;
    if (gnt !== 4'b0000 || arb_busy !== 1'b1 || arb_owner !== 2'd1) begin
      errors++; $display("FAIL drop_dead: gnt=%b busy=%b owner=%0d, want 0000/1/1", gnt, arb_busy, arb_owner);
    end
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== 4'b1000 || fifo_buf_in !== 8'h44 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL drop_next: gnt=%b data=%h busy=%b, want 1000/44/0", gnt, fifo_buf_in, arb_busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b1000;
    #1;
    checks++;
    if (gnt !== 4'b1000 || arb_busy !== 1'b1 || arb_owner !== 2'd3) begin
      errors++; $display("FAIL mid_burst: gnt=%b busy=%b owner=%0d, want 1000/1/3", gnt, arb_busy, arb_owner);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0) begin
      errors++; $display("FAIL mid_rst_gnt: gnt=%b wr=%b, want 0000/0", gnt, fifo_wr_en);
    end
    @(negedge clk);
    checks++;
    if (arb_busy !== 1'b0 || arb_owner !== 2'd0) begin
      errors++; $display("FAIL mid_rst_state: busy=%b owner=%0d, want 0/0", arb_busy, arb_owner);
    end
    rst = 1'b0; req = 4'b1010;
    #1;
    checks++;
    if (gnt !== 4'b0010 || fifo_buf_in !== 8'h22) begin
      errors++; $display("FAIL mid_rst_after: gnt=%b data=%h, want 0010/22", gnt, fifo_buf_in);
    end
    @(negedge clk);
    req = '0; pop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_stall();
    apply_reset();
    req_data = 32'h44332211;
    fill_to = 4;
    @(negedge clk);
    fill_to = -1; req = 4'b0100;
    #1;
    checks++;
    if (gnt !== 4'b0100 || fifo_counter !== 4'd4) begin
      errors++; $display("FAIL stall_start: gnt=%b cnt=%0d, want 0100/4", gnt, fifo_counter);
    end
    @(negedge clk);
    fill_to = 8;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++; $display("FAIL stall_second: gnt=%b, want 0100", gnt);
    end
    @(negedge clk);
    fill_to = -1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0 || arb_busy !== 1'b1 || fifo_buf_full !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: gnt=%b wr=%b busy=%b full=%b, want 0000/0/1/1", k, gnt, fifo_wr_en, arb_busy, fifo_buf_full);
      end
      @(negedge clk);
    end
    pop = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++; $display("FAIL stall_pop_full: gnt=%b, want 0000", gnt);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (gnt !== 4'b0100 || fifo_buf_in !== 8'h33) begin
        errors++; $display("FAIL stall_resume[%0d]: gnt=%b data=%h, want 0100/33", k, gnt, fifo_buf_in);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (gnt !== 4'b0000 || arb_busy !== 1'b0 || fifo_counter !== 4'd7) begin
      errors++; $display("FAIL stall_end: gnt=%b busy=%b cnt=%0d, want 0000/0/7", gnt, arb_busy, fifo_counter);
    end
    req = '0; pop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_high_wm();
    apply_reset();
    req_data = 32'h44332211;
    fill_to = 6;
    @(negedge clk);
    fill_to = -1; req = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (gnt !== 4'b0000 || fifo_counter !== 4'd6) begin
        errors++; $display("FAIL wm_block[%0d]: gnt=%b cnt=%0d, want 0000/6", k, gnt, fifo_counter);
      end
      @(negedge clk);
    end
    pop = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++; $display("FAIL wm_pop_cycle: gnt=%b, want 0000", gnt);
    end
    @(negedge clk);
    pop = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0010 || fifo_counter !== 4'd5 || fifo_buf_in !== 8'h22) begin
      errors++; $display("FAIL wm_grant: gnt=%b cnt=%0d data=%h, want 0010/5/22", gnt, fifo_counter, fifo_buf_in);
    end
    @(negedge clk);
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_drop_req();
    test_reset_mid_burst();
    test_full_stall();
    test_high_wm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
